// File: rtl/nand_sweep_checker.sv
`timescale 1ns/1ps
// nand_sweep_checker: exhaustive sweep tester for an N-input gate cell.
// Walks vec_out through every input combination, holds each vector for
// SETTLE+1 cycles, then samples the gate output for one cycle and compares
// it with the expected gate function. It reports the mismatch count, the
// first failing vector and pass/fail.
//
// Control pulses: start begins a sweep from IDLE or DONE and is ignored
// while busy. abort ends a sweep in progress, wins over start, and has no
// effect when idle or done. There is no other handshake.
module nand_sweep_checker #(
    parameter int N_IN   = 2,   // gate input count, 2..8
    parameter int SETTLE = 2,   // extra hold cycles per vector, 0..15
    parameter int FUNC   = 0    // 0=NAND 1=NOR 2=AND 3=OR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            dut_out,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_valid,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);
    localparam logic [N_IN-1:0] VEC_LAST   = '1;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            ffv_q, ffv_d;
    logic            pass_q, pass_d;

    logic            exp_bit;
    logic            mismatch;
    logic [N_IN:0]   err_next;

    // Expected gate response for the vector currently on the GUT inputs.
    always_comb begin
        exp_bit = 1'b0;
        if (FUNC == 0) begin
            exp_bit = ~&vec_q;
        end else if (FUNC == 1) begin
            exp_bit = ~|vec_q;
        end else if (FUNC == 2) begin
            exp_bit = &vec_q;
        end else begin
            exp_bit = |vec_q;
        end
    end

    assign mismatch = dut_out ^ exp_bit;
    // err_count is one bit wider than the vector, so 2^N_IN mismatches fit.
    assign err_next = mismatch ? (err_q + (N_IN+1)'(1)) : err_q;

    // Next-state and datapath updates for the sweep FSM.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_d   = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                    pass_d  = 1'b0;
                    vec_d   = '0;
                    cnt_d   = SETTLE_CNT;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    vec_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    // The compare of this cycle is dropped; partial results stay.
                    vec_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    err_d = err_next;
                    if (mismatch && !ffv_q) begin
                        ff_d  = vec_q;
                        ffv_d = 1'b1;
                    end
                    if (vec_q == VEC_LAST) begin
                        pass_d  = (err_next == '0);
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + N_IN'(1);
                        cnt_d   = SETTLE_CNT;
                        state_d = ST_APPLY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= 4'd0;
            err_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_out          = vec_q;
    assign busy             = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
    assign done             = (state_q == ST_DONE);
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail       = ff_q;
    assign first_fail_valid = ffv_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_nand_sweep_checker.sv
`timescale 1ns/1ps
// Bench for nand_sweep_checker. Unit 0: N_IN=2, SETTLE=1, NAND.
// Unit 1: N_IN=3, SETTLE=0, NOR. Each GUT is a truth table held by the bench.
module tb_nand_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_r [2];
    logic       abort_r [2];
    logic [7:0] tt [2];

    // unit 0 wires
    logic [1:0] vec_a, ff_a;
    logic [2:0] err_a;
    logic       busy_a, done_a, pass_a, ffv_a, dout_a;
    logic [1:0] st_a;
    // unit 1 wires
    logic [2:0] vec_b, ff_b;
    logic [3:0] err_b;
    logic       busy_b, done_b, pass_b, ffv_b, dout_b;
    logic [1:0] st_b;

    assign dout_a = tt[0][vec_a];
    assign dout_b = tt[1][vec_b];

    nand_sweep_checker #(.N_IN(2), .SETTLE(1), .FUNC(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .abort(abort_r[0]),
        .dut_out(dout_a), .vec_out(vec_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .first_fail(ff_a),
        .first_fail_valid(ffv_a), .state_dbg(st_a)
    );

    nand_sweep_checker #(.N_IN(3), .SETTLE(0), .FUNC(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .abort(abort_r[1]),
        .dut_out(dout_b), .vec_out(vec_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .first_fail(ff_b),
        .first_fail_valid(ffv_b), .state_dbg(st_b)
    );

    // Uniform views of both units.
    logic [7:0] vec_w [2];
    logic [8:0] err_w [2];
    logic [7:0] ff_w  [2];
    logic       busy_w [2], done_w [2], pass_w [2], ffv_w [2];
    assign vec_w[0]  = {6'b0, vec_a};
    assign vec_w[1]  = {5'b0, vec_b};
    assign err_w[0]  = {6'b0, err_a};
    assign err_w[1]  = {5'b0, err_b};
    assign ff_w[0]   = {6'b0, ff_a};
    assign ff_w[1]   = {5'b0, ff_b};
    assign busy_w[0] = busy_a;  assign busy_w[1] = busy_b;
    assign done_w[0] = done_a;  assign done_w[1] = done_b;
    assign pass_w[0] = pass_a;  assign pass_w[1] = pass_b;
    assign ffv_w[0]  = ffv_a;   assign ffv_w[1]  = ffv_b;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        int         unit;
        logic [7:0] tt;
        int         exp_err;
        int         exp_ff;
        bit         exp_ffv;
    } vec_rec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the sweep result follows directly from the gate rule and the GUT table.
    task automatic model(input int u, input logic [7:0] t,
                         output int e, output int ff, output bit ffv);
        int  n;
        int  f;
        bit  all1, any1, want;
        n = (u == 0) ? 2 : 3;
        f = (u == 0) ? 0 : 1;
        e = 0; ff = 0; ffv = 1'b0;
        for (int v = 0; v < (1 << n); v++) begin
            all1 = (v == (1 << n) - 1);
            any1 = (v != 0);
            case (f)
                0: want = !all1;
                1: want = !any1;
                2: want = all1;
                default: want = any1;
            endcase
            if (t[v] != want) begin
                e++;
                if (!ffv) begin
                    ff  = v;
                    ffv = 1'b1;
                end
            end
        end
    endtask

    task automatic check_reset_vals(input int u, input string tag);
        check({tag, " vec"},  32'(vec_w[u]),  0);
        check({tag, " busy"}, 32'(busy_w[u]), 0);
        check({tag, " done"}, 32'(done_w[u]), 0);
        check({tag, " pass"}, 32'(pass_w[u]), 0);
        check({tag, " err"},  32'(err_w[u]),  0);
        check({tag, " ff"},   32'(ff_w[u]),   0);
        check({tag, " ffv"},  32'(ffv_w[u]),  0);
    endtask

    // Runs one full sweep; extra_at >= 0 pulses start that many cycles into busy.
    task automatic run_sweep(input int u, input logic [7:0] t, input int exp_err,
                             input int exp_ff, input bit exp_ffv, input int extra_at,
                             input string tag);
        int n, period, total, cyc, seq_err;
        logic [7:0] e;
        n      = (u == 0) ? 2 : 3;
        period = ((u == 0) ? 1 : 0) + 2;
        total  = (1 << n) * period;
        tt[u]  = t;
        exp_q.delete();
        for (int k = 0; k < total; k++) exp_q.push_back(8'(k / period));
        @(negedge clk);
        start_r[u] = 1'b1;
        @(negedge clk);
        start_r[u] = 1'b0;
        cyc = 0;
        seq_err = 0;
        while (busy_w[u] && cyc < 1000) begin
            if (cyc == 0)
                check({tag, " cleared"}, {23'b0, done_w[u], err_w[u]} | 32'(ffv_w[u]), 0);
            start_r[u] = (cyc == extra_at);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (vec_w[u] !== e) seq_err++;
            end else begin
                seq_err++;
            end
            cyc++;
            @(negedge clk);
        end
        start_r[u] = 1'b0;
        check({tag, " busy_len"}, 32'(cyc), 32'(total));
        check({tag, " vec_seq"},  32'(seq_err), 0);
        check({tag, " done"},     32'(done_w[u]), 1);
        check({tag, " pass"},     32'(pass_w[u]), 32'(exp_err == 0));
        check({tag, " err"},      32'(err_w[u]), 32'(exp_err));
        check({tag, " ffv"},      32'(ffv_w[u]), 32'(exp_ffv));
        if (exp_ffv) check({tag, " ff"}, 32'(ff_w[u]), 32'(exp_ff));
    endtask

    task automatic wait_vec(input int u, input int k, input string tag);
        int c;
        c = 0;
        while (vec_w[u] !== 8'(k) && c < 100) begin
            @(negedge clk);
            c++;
        end
        check({tag, " reach_vec"}, 32'(c < 100), 1);
    endtask

    vec_rec_t recs [5];

    initial begin
        int   e, ff;
        bit   ffv;
        int   u;
        logic [7:0] t;

        recs[0] = '{0, 8'h07, 0, 0, 1'b0};  // ideal NAND
        recs[1] = '{0, 8'h0F, 1, 3, 1'b1};  // stuck-at-1
        recs[2] = '{0, 8'h00, 3, 0, 1'b1};  // stuck-at-0
        recs[3] = '{1, 8'hFE, 8, 0, 1'b1};  // inverted NOR
        recs[4] = '{1, 8'h01, 0, 0, 1'b0};  // ideal NOR

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_r[i] = 1'b0;
            abort_r[i] = 1'b0;
            tt[i] = 8'h00;
        end
        #12;
        check_reset_vals(0, "rst_a");
        check_reset_vals(1, "rst_b");
        @(negedge clk);
        rst_n = 1'b1;

        // Table of spec scenarios.
        for (int i = 0; i < 5; i++)
            run_sweep(recs[i].unit, recs[i].tt, recs[i].exp_err, recs[i].exp_ff,
                      recs[i].exp_ffv, -1, $sformatf("tbl%0d", i));

        // abort while done changes nothing
        @(negedge clk);
        abort_r[1] = 1'b1;
        @(negedge clk);
        abort_r[1] = 1'b0;
        @(negedge clk);
        check("abort_in_done done", 32'(done_w[1]), 1);
        check("abort_in_done vec",  32'(vec_w[1]), 7);

        // Abort during vector 2 APPLY, then clean sweep.
        tt[0] = 8'h00;
        @(negedge clk);
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        wait_vec(0, 2, "abort_a");
        abort_r[0] = 1'b1;
        @(negedge clk);
        abort_r[0] = 1'b0;
        check("abort_a busy", 32'(busy_w[0]), 0);
        check("abort_a done", 32'(done_w[0]), 0);
        check("abort_a vec",  32'(vec_w[0]), 0);
        check("abort_a err",  32'(err_w[0]), 2);
        check("abort_a ffv",  32'(ffv_w[0]), 1);
        run_sweep(0, 8'h07, 0, 0, 1'b0, -1, "after_abort");

        // start together with abort while busy: abort wins, no restart.
        tt[1] = 8'hFE;
        @(negedge clk);
        start_r[1] = 1'b1;
        @(negedge clk);
        start_r[1] = 1'b0;
        wait_vec(1, 3, "sa_b");
        start_r[1] = 1'b1;
        abort_r[1] = 1'b1;
        @(negedge clk);
        start_r[1] = 1'b0;
        abort_r[1] = 1'b0;
        check("sa_b busy", 32'(busy_w[1]), 0);
        check("sa_b vec",  32'(vec_w[1]), 0);
        check("sa_b err",  32'(err_w[1]), 3);
        @(negedge clk);
        check("sa_b stays_idle", 32'(busy_w[1]), 0);

        // Asynchronous reset mid-sweep.
        tt[0] = 8'h00;
        @(negedge clk);
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        wait_vec(0, 2, "arst");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals(0, "arst_a");
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, 8'h07, 0, 0, 1'b0, 4, "post_rst");

        // Randomized GUT tables against the reference model.
        for (int r = 0; r < 12; r++) begin
            u = $urandom_range(0, 1);
            t = 8'($urandom);
            model(u, t, e, ff, ffv);
            run_sweep(u, t, e, ff, ffv, $urandom_range(0, 10), $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nand_sweep_checker.md
# nand_sweep_checker

Parametrised exhaustive-sweep tester for an N-input gate cell. It drives every input combination onto an external gate under test (GUT) and holds each vector for a programmable settle time. It samples the GUT output, compares it against the expected gate function and reports the mismatch count, the first failing vector and pass/fail. It sits in the simulation/characterisation harness beside the transistor-level gate cells and replaces free-running per-input clock stimulus with a deterministic, self-checking sweep.

## Interface

Parameters:
- N_IN, 2, GUT input count (legal 2..8).
- SETTLE, 2, extra hold cycles per vector before sampling (legal 0..15).
- FUNC, 0, expected function: 0=NAND, 1=NOR, 2=AND, 3=OR.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a sweep when in IDLE or DONE.
- abort  in  1  pulse; ends a sweep in progress.
- dut_out  in  1  GUT output, synchronous to clk.
- vec_out  out  N_IN  vector driven onto GUT inputs (bit 0 = first input).
- busy  out  1  sweep in progress.
- done  out  1  sweep completed; held until next start or reset.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  N_IN+1  mismatch count, range 0..2^N_IN, never wraps.
- first_fail  out  N_IN  first mismatching vector.
- first_fail_valid  out  1  first_fail holds a captured value.

## Operation

- FSM states: IDLE, APPLY, SAMPLE, DONE.
- Reset values: state IDLE, vec_out 0, busy 0, done 0, pass 0, err_count 0, first_fail 0, first_fail_valid 0, settle counter 0.
- IDLE, start=1: clear err_count, first_fail, first_fail_valid, done and pass. Set vec_out=0, busy=1, settle counter=SETTLE, then go to APPLY.
- APPLY: decrement the settle counter each cycle. Go to SAMPLE when the counter is 0. If SETTLE=0, APPLY lasts exactly one cycle.
- SAMPLE, one cycle:
  - Compare dut_out with expected(vec_out). If they differ, increment err_count.
  - On the first mismatch of the sweep, capture first_fail=vec_out and set first_fail_valid=1.
  - If vec_out is all ones, go to DONE. Otherwise increment vec_out, reload the settle counter and go to APPLY.
- Expected function: NAND = ~&vec, NOR = ~|vec, AND = &vec, OR = |vec.
- DONE: busy=0, done=1, pass=(err_count==0). vec_out keeps its last value. start=1 restarts exactly as from IDLE.
- abort=1 in APPLY or SAMPLE: the current compare is discarded. Go to IDLE with busy=0, done=0, vec_out=0. err_count and first_fail keep their partial values until the next start.
- abort in IDLE or DONE: no effect.
- start while busy: ignored.
- start and abort together while busy: abort wins. The following start pulse begins a new sweep.
- Reset assertion at any point, including mid-sweep, forces reset values immediately, independent of clk.

## Timing

- First vector: the start edge. vec_out=0 is visible the cycle after start is sampled.
- Per-vector period: SETTLE+2 cycles, made of SETTLE+1 APPLY cycles and 1 SAMPLE cycle.
- Sample point: dut_out is sampled on the rising edge that ends the SAMPLE cycle. The GUT path must settle within SETTLE+1 cycles.
- Sweep length: busy is high for exactly 2^N_IN × (SETTLE+2) cycles.
- done and pass rise on the edge that ends the last SAMPLE cycle, which is the same edge on which busy falls.
- Counters: err_count is N_IN+1 bits wide, so 2^N_IN fits exactly and no saturation logic is needed. vec_out increments unsigned, and the all-ones vector is the terminal condition, so vec_out never wraps within a sweep.

## Test plan

- N_IN=2, SETTLE=1, FUNC=NAND, ideal NAND GUT, start pulse: vec_out sequence 0,1,2,3, each held 3 cycles. busy is high for 12 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0.
- Same configuration, GUT stuck-at-1: one mismatch, at vector 3. Result err_count=1, first_fail=2'b11, first_fail_valid=1, pass=0.
- Same configuration, GUT stuck-at-0: mismatches at vectors 0, 1 and 2. Result err_count=3, first_fail=2'b00, pass=0.
- N_IN=3, SETTLE=0, FUNC=NOR, inverted-output GUT: all 8 vectors fail. Result err_count=8 (MSB set), busy high for 16 cycles, pass=0.
- Abort during vector 2, APPLY: next cycle shows busy=0, done=0, vec_out=0, and err_count keeps its partial value. A following start runs a full clean sweep to done=1.
- rst_n low for part of a cycle mid-sweep: all outputs reach reset values without a clock edge. After release, start produces a normal sweep. A start pulse while busy changes nothing.
